// File: rtl/n64adv2_rst_arbiter.sv
// ============================================================================
// Module   : n64adv2_rst_arbiter
// Purpose  : Arbitrates IGR/CPU console-reset requests and sequences N64_nRST
//            (qualify, drive, release, cooldown). Optional build macro
//            RST_ARB_EVENT_CNT_EN enables the saturating reset-event counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module n64adv2_rst_arbiter #(
  parameter int unsigned          CNT_W           = 20,
  parameter logic [CNT_W-1:0]     HOLD_CYCLES     = CNT_W'(400000),
  parameter logic [CNT_W-1:0]     RST_CYCLES      = CNT_W'(20'hFFFFF),
  parameter logic [CNT_W-1:0]     RELEASE_TIMEOUT = CNT_W'(4000),
  parameter logic [CNT_W-1:0]     COOLDOWN_CYCLES = CNT_W'(40000)
) (
  input  logic       CTRL_CLK,
  input  logic       CTRL_RST,
  input  logic       igr_req_i,
  input  logic       cpu_req_i,
  input  logic [1:0] rst_mask_i,
  input  logic       rst_sense_i,
  output logic       drv_rst_o,
  output logic       rst_busy_o,
  output logic [1:0] rst_src_o,
  output logic       ext_rst_o,
  output logic       rst_fault_o,
  output logic [7:0] rst_evt_cnt_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    QUALIFY  = 3'd1,
    ASSERT   = 3'd2,
    RELEASE  = 3'd3,
    COOLDOWN = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_CYCLES     - CNT_W'(1);
  localparam logic [CNT_W-1:0] RST_LAST  = RST_CYCLES      - CNT_W'(1);
  localparam logic [CNT_W-1:0] TO_LAST   = RELEASE_TIMEOUT - CNT_W'(1);
  localparam logic [CNT_W-1:0] CD_LAST   = COOLDOWN_CYCLES - CNT_W'(1);

  localparam logic [1:0] SRC_IGR = 2'b01;
  localparam logic [1:0] SRC_CPU = 2'b10;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drv_q, drv_d;
  logic             busy_q, busy_d;
  logic [1:0]       src_q, src_d;
  logic             ext_q, ext_d;
  logic             fault_q, fault_d;
  logic             igr_v, cpu_v;

  assign igr_v = igr_req_i & ~rst_mask_i[0] & ~ext_q;
  assign cpu_v = cpu_req_i & ~rst_mask_i[1] & ~ext_q;

  // Console button reset: pad low while we are neither driving nor waiting for it to rise.
  assign ext_d  = ~rst_sense_i & ~drv_q & (state_q != RELEASE);
  assign busy_d = (state_d != IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    drv_d   = drv_q;
    src_d   = src_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cpu_v) begin
          state_d = ASSERT;
          src_d   = SRC_CPU;
          drv_d   = 1'b1;
        end else if (igr_v) begin
          state_d = QUALIFY;
        end
      end
      QUALIFY: begin
        if (cpu_v) begin
          state_d = ASSERT;
          src_d   = SRC_CPU;
          drv_d   = 1'b1;
          cnt_d   = '0;
        end else if (!igr_v) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = ASSERT;
          src_d   = SRC_IGR;
          drv_d   = 1'b1;
          cnt_d   = '0;
        end
      end
      ASSERT: begin
        if (cnt_q == RST_LAST) begin
          state_d = RELEASE;
          drv_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      RELEASE: begin
        if (rst_sense_i) begin
          state_d = COOLDOWN;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = COOLDOWN;
          fault_d = 1'b1;
          cnt_d   = '0;
        end
      end
      COOLDOWN: begin
        // Counter parks on its last value so a held combo cannot wrap it.
        if (cnt_q == CD_LAST) begin
          cnt_d = cnt_q;
          if (!igr_req_i) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        drv_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CTRL_CLK or posedge CTRL_RST) begin
    if (CTRL_RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      drv_q   <= 1'b0;
      busy_q  <= 1'b0;
      src_q   <= 2'b00;
      ext_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drv_q   <= drv_d;
      busy_q  <= busy_d;
      src_q   <= src_d;
      ext_q   <= ext_d;
      fault_q <= fault_d;
    end
  end

  assign drv_rst_o   = drv_q;
  assign rst_busy_o  = busy_q;
  assign rst_src_o   = src_q;
  assign ext_rst_o   = ext_q;
  assign rst_fault_o = fault_q;

`ifdef RST_ARB_EVENT_CNT_EN
  logic [7:0] evt_cnt_q;
  logic       assert_entry;

  assign assert_entry = (state_d == ASSERT) && (state_q != ASSERT);

  always_ff @(posedge CTRL_CLK or posedge CTRL_RST) begin
    if (CTRL_RST) begin
      evt_cnt_q <= 8'h00;
    end else if (assert_entry && (evt_cnt_q != 8'hFF)) begin
      evt_cnt_q <= evt_cnt_q + 8'h01;
    end
  end

  assign rst_evt_cnt_o = evt_cnt_q;
`else
  assign rst_evt_cnt_o = 8'h00;
`endif

endmodule

`default_nettype wire
